uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter that shares one uart_tx instance among N_REQ byte producers
//  (echo path, status reporter, debug dump, ...). It picks one pending request,

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between N_REQ byte producers using round-robin arbitration.
//   When the TX is free, one pending request is picked and its byte is captured.
//   The arbiter then issues a single-cycle tx_start and follows tx_busy until the
//   frame ends. It re-arbitrates only after that.
//
// Ports
//   clk        system clock, posedge
//   reset      asynchronous, active-high
//   req        per-requester "byte pending" level
//   req_data   requester i byte on [i*DATA_W +: DATA_W]
//   gnt        one-hot, 1-cycle pulse: byte of requester i taken
//   tx_start   1-cycle start pulse to uart_tx
//   tx_data    byte being sent; held until the next grant
//   tx_busy    high from uart_tx while a frame is shifting
//   active_id  index of the requester owning the TX
//   active     high from grant until the frame completes
//   to_err     1-cycle pulse: tx_busy never rose after tx_start
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | TX free; grant the first pending requester from rr onward
// START     | tx_start/gnt pulse visible; clear busy-wait counter
// WAIT_BUSY | waiting for uart_tx to raise tx_busy (bounded by BUSY_TO)
// WAIT_DONE | frame shifting; release ownership when tx_busy falls

module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int BUSY_TO = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  active_id,
    output logic                      active,
    output logic                      to_err
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [IDW-1:0]      active_id_q, active_id_d;
    logic                active_q, active_d;
    logic                to_err_q, to_err_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [DATA_W-1:0]   data_arr [N_REQ];
    logic [IDW-1:0]      win;
    logic                win_vld;
    logic [IDW:0]        idx_w;
    logic [IDW-1:0]      rr_next;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Search rr, rr+1, ... with an explicit wrap so non-power-of-2 N_REQ works.
    // idx_w is one bit wider than an index so rr+k never overflows before the wrap.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx_w   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_w = {1'b0, rr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(N_REQ)) begin
                idx_w = idx_w - (IDW+1)'(N_REQ);
            end
            if (!win_vld && req[idx_w[IDW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx_w[IDW-1:0];
            end
        end
    end

    // After serving the owner, it becomes the lowest-priority requester.
    assign rr_next = (active_id_q == IDW'(N_REQ - 1)) ? '0 : active_id_q + IDW'(1);

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        active_id_d = active_id_q;
        active_d    = active_q;
        to_err_d    = 1'b0;
        rr_d        = rr_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                // A busy TX here is a foreign or stale frame: hold off until it ends.
                if (win_vld && !tx_busy) begin
                    gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    tx_start_d  = 1'b1;
                    tx_data_d   = data_arr[win];
                    active_d    = 1'b1;
                    active_id_d = win;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TO - 1)) begin
                    // BUSY_TO cycles without tx_busy: drop the byte, no retry.
                    cnt_d    = CW'(BUSY_TO);
                    to_err_d = 1'b1;
                    active_d = 1'b0;
                    rr_d     = rr_next;
                    state_d  = IDLE;
                end else if (cnt_q != CW'(BUSY_TO)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    rr_d     = rr_next;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            active_id_q <= '0;
            active_q    <= 1'b0;
            to_err_q    <= 1'b0;
            rr_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            active_id_q <= active_id_d;
            active_q    <= active_d;
            to_err_q    <= to_err_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign active_id = active_id_q;
    assign active    = active_q;
    assign to_err    = to_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter.
//   Includes a small uart_tx stand-in that raises tx_busy one clock after tx_start
//   and keeps it high for frame_len clocks. It can also hold tx_busy stuck low
//   or stuck high.
//   An ownership-level model predicts every registered output on each cycle.
//   Directed scenarios add literal expectations on top of the model.

module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*W-1:0] req_data = '0;
    logic          tx_busy = 1'b0;
    logic [N-1:0]  gnt;
    logic          tx_start;
    logic [W-1:0]  tx_data;
    logic [1:0]    active_id;
    logic          active;
    logic          to_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .BUSY_TO(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .active_id (active_id),
        .active    (active),
        .to_err    (to_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // uart_tx stand-in: 0 = normal frames, 1 = busy stuck low, 2 = busy stuck high
    int busy_mode = 0;
    int frame_len = 5;
    int busy_left = 0;

    always @(negedge clk) begin
        if (busy_mode == 2) begin
            tx_busy = 1'b1;
        end else if (busy_left > 0) begin
            tx_busy = 1'b1;
            busy_left--;
        end else begin
            tx_busy = 1'b0;
        end
        if (tx_start && busy_mode == 0) busy_left = frame_len;
    end

    // Ownership model: who holds the TX, how long since the grant, and whether
    // busy has been seen yet.
    logic [N-1:0] e_gnt = '0;
    logic         e_start = 1'b0;
    logic [W-1:0] e_data = '0;
    logic         e_active = 1'b0;
    logic [1:0]   e_id = '0;
    logic         e_err = 1'b0;
    int           m_owner = -1;
    int           m_age = 0;
    int           m_rr = 0;
    int           m_w = -1;
    bit           m_busy_seen = 1'b0;
    logic [1:0]   m_c;

    always @(posedge clk) begin
        e_gnt   = '0;
        e_start = 1'b0;
        e_err   = 1'b0;
        if (reset) begin
            e_data = '0; e_active = 1'b0; e_id = '0;
            m_owner = -1; m_rr = 0;
        end else if (m_owner < 0) begin
            if (req != 0 && !tx_busy) begin
                m_w = -1;
                for (int k = 0; k < N; k++) begin
                    m_c = 2'((m_rr + k) % N);
                    if (m_w < 0 && req[m_c]) m_w = int'(m_c);
                end
                m_owner = m_w; m_age = 0; m_busy_seen = 1'b0;
                e_gnt = 4'b0001 << m_w;
                e_start = 1'b1;
                e_data = req_data[m_w*W +: W];
                e_active = 1'b1;
                e_id = 2'(m_w);
            end
        end else begin
            m_age++;
            if (m_age >= 2) begin
                if (m_busy_seen) begin
                    if (!tx_busy) begin
                        e_active = 1'b0; m_rr = (m_owner + 1) % N; m_owner = -1;
                    end
                end else if (tx_busy) begin
                    m_busy_seen = 1'b1;
                end else if (m_age - 1 == TO) begin
                    e_err = 1'b1;
                    e_active = 1'b0; m_rr = (m_owner + 1) % N; m_owner = -1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("outputs_vs_model", {gnt, tx_start, tx_data, active_id, active, to_err},
            {e_gnt, e_start, e_data, e_id, e_active, e_err});
        chk("start_while_busy", tx_start & tx_busy, 1'b0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n, cnt;
    logic [W-1:0] seq [5];

    initial begin
        // 1: reset held with all requests pending
        reset = 1'b1; req = 4'b1111; req_data = 32'h1312_1110;
        repeat (5) begin
            tick;
            chk("t1_gnt", gnt, 4'b0000);
            chk("t1_start", tx_start, 1'b0);
            chk("t1_data", tx_data, 8'h00);
            chk("t1_active", active, 1'b0);
        end
        @(negedge clk); req = '0; reset = 1'b0;

        // 2: single requester 2, 100-clk frame
        frame_len = 100;
        @(negedge clk); req = 4'b0100; req_data = 32'h00A5_0000;
        n = 0;
        do begin tick; n++; end while (gnt == 0 && n < 20);
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_start", tx_start, 1'b1);
        chk("t2_data", tx_data, 8'hA5);
        chk("t2_id", active_id, 2'd2);
        @(negedge clk); req = '0;
        cnt = 1;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (!active) break;
            cnt++;
        end
        chk("t2_active_len", cnt, 102);

        // 3: all requesters, rr restarted at 0 by reset
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        frame_len = 5;
        req_data = 32'h1312_1110; req = 4'b1111;
        cnt = 0;
        for (int i = 0; i < 400 && cnt < 5; i++) begin
            tick;
            if (tx_start) begin seq[cnt] = tx_data; cnt++; end
        end
        @(negedge clk); req = '0;
        chk("t3_starts", cnt, 5);
        chk("t3_seq0", seq[0], 8'h10);
        chk("t3_seq1", seq[1], 8'h11);
        chk("t3_seq2", seq[2], 8'h12);
        chk("t3_seq3", seq[3], 8'h13);
        chk("t3_seq4", seq[4], 8'h10);
        for (int i = 0; i < 50; i++) begin tick; if (!active) break; end
        chk("t3_idle", active, 1'b0);

        // 4: busy never rises; rr is 1 after serving 0
        busy_mode = 1;
        @(negedge clk); req_data = 32'h0000_2120; req = 4'b0011;
        for (int i = 0; i < 20; i++) begin tick; if (tx_start) break; end
        chk("t4_start", tx_start, 1'b1);
        chk("t4_id", active_id, 2'd1);
        chk("t4_data", tx_data, 8'h21);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin tick; cnt++; if (to_err) break; end
        chk("t4_to_err", to_err, 1'b1);
        chk("t4_to_delay", cnt, TO + 1);
        chk("t4_active_drop", active, 1'b0);
        for (int i = 0; i < 20; i++) begin tick; if (tx_start) break; end
        chk("t4_next_id", active_id, 2'd0);
        chk("t4_next_data", tx_data, 8'h20);
        @(negedge clk); req = '0;
        for (int i = 0; i < 40; i++) begin tick; if (!active) break; end
        chk("t4_idle", active, 1'b0);
        busy_mode = 0;

        // 5: foreign busy frame blocks granting
        @(negedge clk); busy_mode = 2;
        @(negedge clk); req = 4'b0001; req_data = 32'h0000_0055;
        repeat (10) begin tick; chk("t5_hold", gnt, 4'b0000); end
        @(negedge clk); busy_mode = 0;
        for (int i = 0; i < 10; i++) begin tick; if (gnt != 0) break; end
        chk("t5_gnt", gnt, 4'b0001);
        chk("t5_data", tx_data, 8'h55);
        @(negedge clk); req = '0;
        for (int i = 0; i < 50; i++) begin tick; if (!active) break; end
        chk("t5_idle", active, 1'b0);

        // 6: reset while the frame is shifting
        frame_len = 50;
        @(negedge clk); req = 4'b0100; req_data = 32'h0077_0000;
        for (int i = 0; i < 20; i++) begin tick; if (tx_start) break; end
        chk("t6_start", tx_start, 1'b1);
        @(negedge clk); req = '0;
        repeat (5) tick;
        chk("t6_in_frame", {active, tx_busy}, 2'b11);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("t6_async_clear", {gnt, tx_start, tx_data, active_id, active, to_err}, 17'd0);
        repeat (2) tick;
        @(negedge clk); reset = 1'b0; req = 4'b0010; req_data = 32'h0000_3300;
        for (int i = 0; i < 100; i++) begin tick; if (tx_start) break; end
        chk("t6_gnt", gnt, 4'b0010);
        chk("t6_id", active_id, 2'd1);
        chk("t6_data", tx_data, 8'h33);
        @(negedge clk); req = '0;
        for (int i = 0; i < 100; i++) begin tick; if (!active) break; end
        chk("t6_idle", active, 1'b0);

        repeat (3) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
